// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and UART-side signals around the UART TX arbiter.
// The arbiter takes the slave modport; the requesters/UART model drive the master side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_start;
  logic [7:0]           uart_data;
  logic                 uart_busy;
  logic [1:0]           grant_id;
  logic                 locked;
  logic                 active;
  logic                 err_timeout;
  logic                 err_clear;

  modport master (
    output req_valid, req_data, req_last, uart_busy, err_clear,
    input  req_ready, uart_start, uart_data, grant_id, locked, active, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_busy, err_clear,
    output req_ready, uart_start, uart_data, grant_id, locked, active, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters into a single UART transmitter,
// with per-requester packet locking and a sticky timeout when the UART never reports busy.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      rr_q, rr_d;
  logic            locked_q, locked_d;
  logic            start_q, start_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            win_valid;
  logic [1:0]      win_idx;
  logic [7:0]      win_data;
  logic            win_last;
  logic            timeout;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (32'(idx) + 32'd1 >= NUM_REQ) ? 2'd0 : idx + 2'd1;
  endfunction

  // Winner selection: the lock owner only, otherwise first valid at or above rr_q, then wrap.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = grant_q;
    if (locked_q) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (2'(i) == grant_q) begin
          win_valid = bus.req_valid[i];
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!win_valid && bus.req_valid[i] && (2'(i) >= rr_q)) begin
          win_valid = 1'b1;
          win_idx   = 2'(i);
        end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!win_valid && bus.req_valid[i]) begin
          win_valid = 1'b1;
          win_idx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    win_data = 8'h00;
    win_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (2'(i) == win_idx) begin
        win_data = bus.req_data[8*i +: 8];
        win_last = bus.req_last[i];
      end
    end
  end

  // Ready is gated by reset so nothing looks accepted while the block is held in reset.
  always_comb begin
    bus.req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (reset && (state_q == StIdle) && win_valid && (2'(i) == win_idx)) begin
        bus.req_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    locked_d = locked_q;
    start_d  = 1'b0;
    err_d    = err_q;
    cnt_d    = '0;
    timeout  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          data_d  = win_data;
          grant_d = win_idx;
          start_d = 1'b1;
          state_d = StStart;
          if (win_last) begin
            locked_d = 1'b0;
            rr_d     = next_idx(win_idx);
          end else begin
            locked_d = 1'b1;
          end
        end
      end
      StStart: begin
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.uart_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q >= CntW'(BUSY_TIMEOUT - 1)) begin
          // The UART never acknowledged: drop the byte and release any lock.
          timeout  = 1'b1;
          state_d  = StIdle;
          locked_d = 1'b0;
          rr_d     = next_idx(grant_q);
        end else begin
          cnt_d = (cnt_q < CntW'(BUSY_TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
        end
      end
      StWaitDone: begin
        if (!bus.uart_busy) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (bus.err_clear) begin
      err_d = 1'b0;
    end else if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      data_q   <= 8'h00;
      grant_q  <= 2'd0;
      rr_q     <= 2'd0;
      locked_q <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      locked_q <= locked_d;
      start_q  <= start_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.uart_start  = start_q;
  assign bus.uart_data   = data_q;
  assign bus.grant_id    = grant_q;
  assign bus.locked      = locked_q;
  assign bus.active      = (state_q != StIdle);
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed byte streams per requester, expected
// (grant, data, locked) tuples queued up front and checked whenever uart_start fires.
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq      = 3;
  localparam int unsigned BusyTimeout = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NumReq)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NumReq),
    .BUSY_TIMEOUT(BusyTimeout)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0] gid;
    logic [7:0] data;
    logic       locked;
  } exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } src_t;

  exp_t exp_q[$];
  src_t src_q[NumReq][$];

  int tests = 0;
  int fails = 0;
  int ready_cycles[NumReq];
  bit force_all     = 1'b1;
  bit start_pending = 1'b0;
  bit uart_en       = 1'b1;
  bit uart_rst      = 1'b0;
  int busy_len      = 4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_src(input int r, input logic [7:0] d, input logic last);
    src_t s;
    s.data = d;
    s.last = last;
    src_q[r].push_back(s);
  endtask

  task automatic push_exp(input logic [1:0] g, input logic [7:0] d, input logic lk);
    exp_t e;
    e.gid    = g;
    e.data   = d;
    e.locked = lk;
    exp_q.push_back(e);
  endtask

  function automatic bit src_pending();
    for (int i = 0; i < NumReq; i++) begin
      if (src_q[i].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while ((src_pending() || exp_q.size() != 0 || bus.active) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 2000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_src_empty(input int r, input string name);
    int n = 0;
    while (src_q[r].size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 500), 1);
  endtask

  task automatic measure_active(output int cnt);
    int n = 0;
    cnt = 0;
    while (n < 500) begin
      @(negedge clk);
      n++;
      if (bus.active) cnt++;
      else if (cnt > 0) break;
    end
  endtask

  // Requester driver: presents queue heads each negedge, pops on an observed handshake.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      if (start_pending) begin
        check("start_latency", 32'(bus.uart_start), 1);
        start_pending = 1'b0;
      end
      for (int i = 0; i < NumReq; i++) begin
        if (force_all) begin
          bus.req_valid[i]      = 1'b1;
          bus.req_data[8*i +: 8] = 8'hFF;
          bus.req_last[i]       = 1'b1;
        end else if (src_q[i].size() != 0) begin
          bus.req_valid[i]      = 1'b1;
          bus.req_data[8*i +: 8] = src_q[i][0].data;
          bus.req_last[i]       = src_q[i][0].last;
        end else begin
          bus.req_valid[i]      = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]       = 1'b0;
        end
      end
      #2;
      for (int i = 0; i < NumReq; i++) begin
        if (bus.req_ready[i]) ready_cycles[i]++;
        if (bus.req_valid[i] && bus.req_ready[i] && !force_all && src_q[i].size() != 0) begin
          void'(src_q[i].pop_front());
          start_pending = 1'b1;
        end
      end
    end
  end

  // UART model: busy for busy_len cycles after each start, unless disabled.
  initial begin
    int cnt;
    cnt = 0;
    bus.uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_rst) cnt = 0;
      else if (cnt > 0) cnt--;
      else if (bus.uart_start && uart_en) cnt = busy_len;
      bus.uart_busy = (cnt > 0);
    end
  end

  // Monitor: every uart_start pops one expected tuple.
  initial begin
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.uart_start) begin
        check("start_pulse_width", 32'(prev), 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_start: grant %0d data %0h, nothing expected",
                   bus.grant_id, bus.uart_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_grant_id", 32'(bus.grant_id), 32'(e.gid));
          check("sb_uart_data", 32'(bus.uart_data), 32'(e.data));
          check("sb_locked", 32'(bus.locked), 32'(e.locked));
        end
      end
      prev = bus.uart_start;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int act;
    bus.err_clear = 1'b0;
    for (int i = 0; i < NumReq; i++) ready_cycles[i] = 0;

    // Reset values, with every requester valid while reset is held.
    repeat (2) @(negedge clk);
    #3;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_active", 32'(bus.active), 0);
    check("rst_uart_start", 32'(bus.uart_start), 0);
    check("rst_uart_data", 32'(bus.uart_data), 0);
    check("rst_grant_id", 32'(bus.grant_id), 0);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_err_timeout", 32'(bus.err_timeout), 0);
    force_all = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NumReq; i++) ready_cycles[i] = 0;

    // Single byte from requester 1, busy for 10 cycles: 1 START + 1 WAIT_BUSY + 9 WAIT_DONE.
    busy_len = 10;
    push_exp(2'd1, 8'h3A, 1'b0);
    push_src(1, 8'h3A, 1'b1);
    measure_active(act);
    check("single_active_cycles", act, 11);
    check("single_ready_cycles", ready_cycles[1], 1);
    wait_drain("single_drain");

    // rr_ptr is now 2, so with all three valid the order is 2,0,1.
    busy_len = 4;
    push_exp(2'd2, 8'hC2, 1'b0);
    push_exp(2'd0, 8'hC0, 1'b0);
    push_exp(2'd1, 8'hC1, 1'b0);
    push_src(0, 8'hC0, 1'b1);
    push_src(1, 8'hC1, 1'b1);
    push_src(2, 8'hC2, 1'b1);
    wait_drain("rr_from_ptr2_drain");

    // Round robin from reset: 0,1,2,0,1,2.
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    push_exp(2'd0, 8'h10, 1'b0);
    push_exp(2'd1, 8'h20, 1'b0);
    push_exp(2'd2, 8'h30, 1'b0);
    push_exp(2'd0, 8'h11, 1'b0);
    push_exp(2'd1, 8'h21, 1'b0);
    push_exp(2'd2, 8'h31, 1'b0);
    push_src(0, 8'h10, 1'b1);
    push_src(0, 8'h11, 1'b1);
    push_src(1, 8'h20, 1'b1);
    push_src(1, 8'h21, 1'b1);
    push_src(2, 8'h30, 1'b1);
    push_src(2, 8'h31, 1'b1);
    wait_drain("rr_drain");

    // Packet lock: requester 0 sends A0,A1,A2 with gaps while requester 2 waits.
    push_exp(2'd0, 8'hA0, 1'b1);
    push_exp(2'd0, 8'hA1, 1'b1);
    push_exp(2'd0, 8'hA2, 1'b0);
    push_exp(2'd2, 8'hE2, 1'b0);
    push_src(0, 8'hA0, 1'b0);
    push_src(2, 8'hE2, 1'b1);
    wait_src_empty(0, "lock_byte0_taken");
    repeat (20) @(negedge clk);
    #3;
    check("lock_gap_locked", 32'(bus.locked), 1);
    check("lock_gap_grant", 32'(bus.grant_id), 0);
    check("lock_gap_ready", 32'(bus.req_ready), 0);
    push_src(0, 8'hA1, 1'b0);
    wait_src_empty(0, "lock_byte1_taken");
    repeat (20) @(negedge clk);
    #3;
    check("lock_gap2_ready", 32'(bus.req_ready), 0);
    push_src(0, 8'hA2, 1'b1);
    wait_drain("lock_drain");

    // Timeout: UART never goes busy; 1 START + 16 WAIT_BUSY cycles.
    uart_en = 1'b0;
    push_exp(2'd1, 8'h5B, 1'b1);
    push_src(1, 8'h5B, 1'b0);
    measure_active(act);
    check("timeout_active_cycles", act, 17);
    check("timeout_err_set", 32'(bus.err_timeout), 1);
    check("timeout_locked_clr", 32'(bus.locked), 0);
    repeat (5) @(negedge clk);
    check("timeout_err_sticky", 32'(bus.err_timeout), 1);
    bus.err_clear = 1'b1;
    @(negedge clk);
    bus.err_clear = 1'b0;
    check("timeout_err_cleared", 32'(bus.err_timeout), 0);
    uart_en = 1'b1;
    // rr advanced past 1, so 2 goes before 0.
    push_exp(2'd2, 8'h62, 1'b0);
    push_exp(2'd0, 8'h60, 1'b0);
    push_src(0, 8'h60, 1'b1);
    push_src(2, 8'h62, 1'b1);
    wait_drain("timeout_rr_drain");

    // err_clear held across a timeout wins.
    uart_en = 1'b0;
    bus.err_clear = 1'b1;
    push_exp(2'd0, 8'h77, 1'b0);
    push_src(0, 8'h77, 1'b1);
    measure_active(act);
    check("clrprio_active_cycles", act, 17);
    check("clrprio_err", 32'(bus.err_timeout), 0);
    bus.err_clear = 1'b0;
    uart_en = 1'b1;

    // Reset in WAIT_DONE with a lock held by requester 2.
    busy_len = 20;
    push_exp(2'd2, 8'h9C, 1'b1);
    push_src(2, 8'h9C, 1'b0);
    wait_src_empty(2, "rstmid_taken");
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rstmid_uart_start", 32'(bus.uart_start), 0);
    check("rstmid_uart_data", 32'(bus.uart_data), 0);
    check("rstmid_grant_id", 32'(bus.grant_id), 0);
    check("rstmid_locked", 32'(bus.locked), 0);
    check("rstmid_active", 32'(bus.active), 0);
    check("rstmid_err", 32'(bus.err_timeout), 0);
    check("rstmid_req_ready", 32'(bus.req_ready), 0);
    uart_rst = 1'b1;
    busy_len = 4;
    repeat (2) @(negedge clk);
    uart_rst = 1'b0;
    #1 rst_n = 1'b1;
    push_exp(2'd0, 8'hB0, 1'b0);
    push_exp(2'd1, 8'hB1, 1'b0);
    push_exp(2'd2, 8'hB2, 1'b0);
    push_src(0, 8'hB0, 1'b1);
    push_src(1, 8'hB1, 1'b1);
    push_src(2, 8'hB2, 1'b1);
    wait_drain("rstmid_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, meaning the number of byte requesters (2..4).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 16, meaning the cycles to wait for uart_busy to rise after a start pulse.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte available.
REQ-006 SHALL have port req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  NUM_REQ  per-requester flag marking the last byte of a packet.
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept; a transfer occurs on a rising edge where req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port uart_start  output  1  one-cycle request to the UART transmitter.
REQ-010 SHALL have port uart_data  output  8  byte presented to the UART; held stable from capture until return to IDLE.
REQ-011 SHALL have port uart_busy  input  1  UART transmitter busy.
REQ-012 SHALL have port grant_id  output  2  index of the requester owning the current byte or lock.
REQ-013 SHALL have port locked  output  1  high while a packet is in progress.
REQ-014 SHALL have port active  output  1  high whenever the state is not IDLE.
REQ-015 SHALL have port err_timeout  output  1  sticky flag set by a busy timeout.
REQ-016 SHALL have port err_clear  input  1  synchronous clear of err_timeout.

Function
REQ-017 SHALL implement the states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-018 SHALL, in IDLE when unlocked, select the first requester with req_valid high, scanning from rr_ptr upward modulo NUM_REQ.
REQ-019 SHALL, in IDLE when locked, consider only requester grant_id and wait indefinitely for its req_valid.
REQ-020 SHALL drive req_ready[w] combinationally high only in IDLE for winner w; all other ready bits SHALL be 0.
REQ-021 SHALL, on a transfer, register req_data[w] into uart_data, set grant_id=w, and go to START.
REQ-022 SHALL drive uart_start high for exactly the one cycle spent in START, then go to WAIT_BUSY.
REQ-023 SHALL, as a consequence, raise uart_start in the cycle after capture (latency 1).
REQ-024 SHALL, in WAIT_BUSY, go to WAIT_DONE when uart_busy=1.
REQ-025 SHALL, in WAIT_BUSY, go to IDLE and set err_timeout when BUSY_TIMEOUT cycles elapse without uart_busy.
REQ-026 SHALL, in WAIT_DONE, go to IDLE when uart_busy=0.
REQ-027 SHALL, on capture with req_last[w]=0, set locked=1.
REQ-028 SHALL, on capture with req_last[w]=1, clear locked and set rr_ptr=(w+1) mod NUM_REQ.
REQ-029 SHALL, on a timeout, also clear locked and advance rr_ptr past grant_id.
REQ-030 SHALL give err_clear priority over a timeout occurring in the same cycle.
REQ-031 SHALL NOT capture a new byte while a byte from another requester is in flight, nor from a non-locked requester while locked.
REQ-032 SHALL keep the WAIT_BUSY counter at 0 in every other state, and it SHALL saturate at BUSY_TIMEOUT.

Reset
REQ-033 SHALL, on reset low at any time including mid-byte, immediately set state=IDLE.
REQ-034 SHALL, on reset low, set uart_start=0, uart_data=8'h00, grant_id=0, rr_ptr=0, locked=0, err_timeout=0 and the counter to 0.
REQ-035 SHALL, while reset is low, drive req_ready=0 and active=0.

Verification
REQ-036 SHALL verify a single byte: req_valid[1]=1, data 8'h3A, last=1, with busy high for 10 cycles. Required: ready[1] for 1 cycle, uart_start high exactly 1 cycle later with uart_data=8'h3A, active for the full duration, and rr_ptr=2 afterward.
REQ-037 SHALL verify round-robin: all three requesters valid continuously, each byte last=1. Required: grant order 0,1,2,0.
REQ-038 SHALL verify the packet lock: requester 0 sends 3 bytes with last=0,0,1 while requester 2 is held valid. Required: requester 2 is not served until requester 0's third byte is captured, and locked is high across the packet.
REQ-039 SHALL verify the timeout: uart_busy held at 0 after start. Required: return to IDLE after 16 cycles in WAIT_BUSY, err_timeout=1, locked cleared, and err_timeout remains set until err_clear is asserted.
REQ-040 SHALL verify reset mid-operation: reset asserted in WAIT_DONE. Required: all outputs at their reset values immediately, and after release the next valid request is granted from rr_ptr=0.
